// File: rtl/seg_scan_display.sv
// Time-multiplexed 4-digit common-anode seven-segment driver for the timer's BCD
// score, with frame-coherent snapshots, anti-ghost guard, blanking and lose-blink.
module seg_scan_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 250,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned LZB         = 1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] sec_u,
  input  logic [3:0] sec_t,
  input  logic [3:0] sec_h,
  input  logic [3:0] h_sec_u,
  input  logic [3:0] h_sec_t,
  input  logic [3:0] h_sec_h,
  input  logic       show_high,
  input  logic       win_flag,
  input  logic       lose_flag,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'((BLINK_DIV > 0) ? BLINK_DIV - 1 : 0);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_D     = 7'b0100001;

  typedef struct packed {
    logic [3:0] u;
    logic [3:0] t;
    logic [3:0] h;
    logic [3:0] hu;
    logic [3:0] ht;
    logic [3:0] hh;
    logic       show_high;
    logic       win;
    logic       lose;
  } frame_t;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             run;
  frame_t           snap;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;

  logic             tick;
  logic             frame_start;
  logic [1:0]       idx_nxt;
  frame_t           live;
  frame_t           view;
  logic [BLK_W-1:0] blink_cnt_nxt;
  logic             blink_on_nxt;
  logic [6:0]       seg_nxt;
  logic [3:0]       src_u;
  logic [3:0]       src_t;
  logic [3:0]       src_h;
  logic [6:0]       glyph;
  logic             lit;
  logic             hide_h;
  logic             hide_t;

  function automatic logic [6:0] bcd_seg(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // First tick after reset starts a fresh frame at slot 0 instead of advancing.
  assign tick        = (cnt == CNT_LAST);
  assign frame_start = tick && (!run || (idx == 2'd3));
  assign idx_nxt     = run ? idx + 2'd1 : 2'd0;
  assign live        = '{u: sec_u, t: sec_t, h: sec_h, hu: h_sec_u, ht: h_sec_t,
                         hh: h_sec_h, show_high: show_high, win: win_flag,
                         lose: lose_flag};

  // Blink state advances once per frame so every digit sees both phases.
  always_comb begin
    blink_cnt_nxt = blink_cnt;
    blink_on_nxt  = blink_on;
    if (frame_start) begin
      if (!lose_flag || !snap.lose) begin
        blink_cnt_nxt = '0;
        blink_on_nxt  = 1'b1;
      end else if (blink_cnt == BLK_LAST) begin
        blink_cnt_nxt = '0;
        blink_on_nxt  = ~blink_on;
      end else begin
        blink_cnt_nxt = blink_cnt + BLK_W'(1);
      end
    end
  end

  // Pattern for the slot being entered; slot 0 of a new frame decodes the live inputs.
  always_comb begin
    view    = frame_start ? live : snap;
    src_u   = view.show_high ? view.hu : view.u;
    src_t   = view.show_high ? view.ht : view.t;
    src_h   = view.show_high ? view.hh : view.h;
    lit     = !view.lose || blink_on_nxt;
    hide_h  = (LZB != 0) && (src_h == 4'd0);
    hide_t  = hide_h && (src_t == 4'd0);
    glyph   = SEG_BLANK;
    seg_nxt = SEG_BLANK;
    if (view.lose)           glyph = SEG_L;
    else if (view.win)       glyph = SEG_D;
    else if (view.show_high) glyph = SEG_H;
    unique case (idx_nxt)
      2'd0:    seg_nxt = lit ? bcd_seg(src_u) : SEG_BLANK;
      2'd1:    seg_nxt = (lit && !hide_t) ? bcd_seg(src_t) : SEG_BLANK;
      2'd2:    seg_nxt = (lit && !hide_h) ? bcd_seg(src_h) : SEG_BLANK;
      default: seg_nxt = glyph;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt       <= '0;
      idx       <= 2'd0;
      run       <= 1'b0;
      snap      <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      an        <= 4'b1111;
      seg       <= SEG_BLANK;
    end else begin
      cnt       <= tick ? '0 : cnt + CNT_W'(1);
      blink_cnt <= blink_cnt_nxt;
      blink_on  <= blink_on_nxt;
      if (frame_start) snap <= live;
      if (tick) begin
        idx <= idx_nxt;
        run <= 1'b1;
        seg <= seg_nxt;
        an  <= (GUARD == 0) ? ~(4'b0001 << idx_nxt) : 4'b1111;
      end else if (run && (GUARD != 0) && (cnt == GUARD_LAST)) begin
        an <= ~(4'b0001 << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed + randomized bench for seg_scan_display; expected patterns come from a
// number-level display model captured once per scan frame.
module tb_seg_scan_display;

  localparam int unsigned RD  = 4;
  localparam int unsigned BD  = 2;
  localparam int unsigned GD  = 1;
  localparam int unsigned LZ  = 1;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] ENC [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};

  logic       clk;
  logic       clr_n;
  logic [3:0] sec_u, sec_t, sec_h, h_sec_u, h_sec_t, h_sec_h;
  logic       show_high, win_flag, lose_flag;
  logic [3:0] an;
  logic [6:0] seg;

  int checks;
  int failures;
  int slot;

  typedef struct {
    logic [3:0] u, t, h, hu, ht, hh;
    logic       sh, win, lose;
  } snap_t;

  snap_t m_snap;
  int    m_loss_n;
  logic  m_prev_lose;

  seg_scan_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD), .GUARD(GD), .LZB(LZ)) dut (
    .clk(clk), .clr_n(clr_n),
    .sec_u(sec_u), .sec_t(sec_t), .sec_h(sec_h),
    .h_sec_u(h_sec_u), .h_sec_t(h_sec_t), .h_sec_h(h_sec_h),
    .show_high(show_high), .win_flag(win_flag), .lose_flag(lose_flag),
    .an(an), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Displayed number model: a digit above units is hidden when it and every
  // more-significant digit are zero; anything above 9 counts as non-zero.
  function automatic logic [6:0] exp_seg(input int pos, input logic lit);
    logic [3:0] d [3];
    bit upper_zero;
    if (pos == 3) begin
      if (m_snap.lose) return 7'b1000111;
      if (m_snap.win)  return 7'b0100001;
      if (m_snap.sh)   return 7'b0001001;
      return BLANK;
    end
    if (!lit) return BLANK;
    d[0] = m_snap.sh ? m_snap.hu : m_snap.u;
    d[1] = m_snap.sh ? m_snap.ht : m_snap.t;
    d[2] = m_snap.sh ? m_snap.hh : m_snap.h;
    upper_zero = 1'b1;
    for (int j = pos; j < 3; j++) if (d[j] != 4'd0) upper_zero = 1'b0;
    if (pos > 0 && LZ != 0 && upper_zero) return BLANK;
    if (d[pos] > 4'd9) return DASH;
    return ENC[d[pos]];
  endfunction

  // Entered at the negedge of a tick cycle; covers one full digit slot.
  task automatic run_slot();
    int pos;
    logic lit;
    logic [6:0] e;
    logic [3:0] ea;
    pos = slot % 4;
    if (pos == 0) begin
      m_snap.u = sec_u; m_snap.t = sec_t; m_snap.h = sec_h;
      m_snap.hu = h_sec_u; m_snap.ht = h_sec_t; m_snap.hh = h_sec_h;
      m_snap.sh = show_high; m_snap.win = win_flag; m_snap.lose = lose_flag;
      if (m_snap.lose) m_loss_n = m_prev_lose ? m_loss_n + 1 : 0;
      else             m_loss_n = 0;
      m_prev_lose = m_snap.lose;
    end
    lit = !m_snap.lose || (((m_loss_n / BD) % 2) == 0);
    e   = exp_seg(pos, lit);
    ea  = 4'b1111;
    ea[pos] = 1'b0;
    @(posedge clk); @(negedge clk);
    check($sformatf("guard_an_s%0d", slot), {3'b0, an}, {3'b0, 4'b1111});
    check($sformatf("seg_s%0d", slot), seg, e);
    @(posedge clk); @(negedge clk);
    check($sformatf("an_on_s%0d", slot), {3'b0, an}, {3'b0, ea});
    check($sformatf("seg_on_s%0d", slot), seg, e);
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    check($sformatf("an_hold_s%0d", slot), {3'b0, an}, {3'b0, ea});
    slot++;
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) for (int s = 0; s < 4; s++) run_slot();
  endtask

  task automatic set_live(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    sec_h = h; sec_t = t; sec_u = u;
  endtask

  // Releases reset at a negedge and walks up to the first tick cycle.
  task automatic release_reset();
    clr_n = 1'b1;
    slot = 0;
    m_loss_n = 0;
    m_prev_lose = 1'b0;
    for (int i = 0; i < RD - 1; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("prescan_an_%0d", i), {3'b0, an}, {3'b0, 4'b1111});
    end
  endtask

  initial begin
    checks = 0; failures = 0; slot = 0;
    m_loss_n = 0; m_prev_lose = 1'b0;
    clr_n = 1'b0;
    set_live(4'd9, 4'd9, 4'd9);
    h_sec_u = 4'd0; h_sec_t = 4'd0; h_sec_h = 4'd0;
    show_high = 1'b0; win_flag = 1'b0; lose_flag = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_an", {3'b0, an}, {3'b0, 4'b1111});
    check("reset_seg", seg, BLANK);
    release_reset();

    // Full 999 frame, then leading-zero cases.
    run_frames(1);
    set_live(4'd0, 4'd0, 4'd7);
    run_frames(1);
    set_live(4'd0, 4'd5, 4'd0);
    run_frames(1);

    // High score with a mid-frame change that must wait for the wrap.
    show_high = 1'b1;
    h_sec_h = 4'd0; h_sec_t = 4'd2; h_sec_u = 4'd0;
    set_live(4'd9, 4'd9, 4'd9);
    run_slot();
    set_live(4'd1, 4'd2, 4'd3);
    h_sec_h = 4'd4; h_sec_t = 4'd4; h_sec_u = 4'd4;
    run_slot(); run_slot(); run_slot();
    run_frames(1);

    // Lose and win together, blinking units, then lose dropped.
    show_high = 1'b0;
    win_flag = 1'b1; lose_flag = 1'b1;
    set_live(4'd0, 4'd0, 4'd0);
    run_frames(6);
    lose_flag = 1'b0;
    run_frames(1);
    win_flag = 1'b0;

    // Out-of-range nibble.
    set_live(4'd0, 4'd0, 4'hC);
    run_frames(1);
    set_live(4'hA, 4'd0, 4'd3);
    run_frames(1);

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      sec_h   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
      sec_t   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
      sec_u   = 4'($urandom_range(0, 11));
      h_sec_h = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
      h_sec_t = 4'($urandom_range(0, 11));
      h_sec_u = 4'($urandom_range(0, 11));
      show_high = 1'($urandom_range(0, 1));
      win_flag  = 1'($urandom_range(0, 1));
      lose_flag = ($urandom_range(0, 2) != 0);
      run_frames(1);
    end

    // Asynchronous reset in the middle of a lit slot.
    show_high = 1'b0; win_flag = 1'b0; lose_flag = 1'b0;
    set_live(4'd1, 4'd2, 4'd3);
    run_frames(1);
    run_slot();
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    check("pre_reset_an", {3'b0, an}, {3'b0, 4'b1101});
    clr_n = 1'b0;
    #1;
    check("async_an", {3'b0, an}, {3'b0, 4'b1111});
    check("async_seg", seg, BLANK);
    @(posedge clk); @(negedge clk);
    release_reset();
    set_live(4'd0, 4'd4, 4'd2);
    run_frames(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
